// File: rtl/fp_check_pkg.sv
// -----------------------------------------------------------------------------
// fp_check_pkg
// Shared types and constants for the FP result scoreboard.
//   fp_exp_entry_t : one expected-result queue entry. The result field is
//                    always 64 bits wide. 32-bit builds zero-extend into it.
//   SP_CANON_NAN   : single-precision canonical quiet NaN.
//   DP_CANON_NAN   : double-precision canonical quiet NaN.
//   sb_state_e     : scoreboard FSM states.
// -----------------------------------------------------------------------------
package fp_check_pkg;

  localparam int MAX_FLEN = 64;

  localparam logic [31:0] SP_CANON_NAN = 32'h7FC0_0000;
  localparam logic [63:0] DP_CANON_NAN = 64'h7FF8_0000_0000_0000;

  typedef struct packed {
    logic [MAX_FLEN-1:0] result;
    logic [4:0]          flags;
    logic [1:0]          fmt;    // 0 = single, 1 = double
    logic                f2i;    // float-to-int op: never NaN-masked
  } fp_exp_entry_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } sb_state_e;

endpackage

// File: rtl/fp_sb_fifo.sv
// -----------------------------------------------------------------------------
// fp_sb_fifo
// In-order queue of expected entries. The head is read combinationally so the
// compare can happen in the same cycle as the unit strobe.
// Pointers carry one extra wrap bit:
//   full  = pointers differ only in the wrap bit
//   empty = pointers are equal
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-low reset
//   flush             : synchronous flush, empties the queue
//   push, push_data   : write an entry. Ignored when full.
//   pop               : drop the head entry. Ignored when empty.
//   head              : current head entry
//   full, empty, level: occupancy status
// -----------------------------------------------------------------------------
module fp_sb_fifo #(
  parameter int  DEPTH     = 8,
  parameter type payload_t = logic [7:0]
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  payload_t                   push_data,
  input  logic                       pop,
  output payload_t                   head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  payload_t      mem_reg [DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // With a power-of-two depth, the wrapped pointer difference is the occupancy.
  assign level = wr_ptr_reg - rd_ptr_reg;
  assign head  = mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage has no reset. Only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fp_scoreboard.sv
// -----------------------------------------------------------------------------
// fp_scoreboard
// Checks FP unit results against an in-order queue of expected results. The
// check supports variable latency with up to DEPTH operations in flight.
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   exp_*                 : expected-entry push interface
//                           (valid/ready, result, flags, fmt, f2i)
//   dut_ready/result/flags: unit result strobe and data
//   clear                 : synchronous flush of queue, counters and capture
//   level                 : entries held
//   mismatch              : one-cycle pulse per failing compare
//   pass_count/fail_count : saturating compare counters
//   orphan, overflow      : sticky protocol-error flags
//   halted                : FSM is in HALT
//   fail_valid, fail_exp, fail_calc, fail_flags_diff : first-failure capture
// -----------------------------------------------------------------------------
module fp_scoreboard
  import fp_check_pkg::*;
#(
  parameter int FLEN         = 64,
  parameter int DEPTH        = 8,
  parameter bit STOP_ON_FAIL = 1,
  parameter bit NAN_MASK     = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       exp_valid,
  output logic                       exp_ready,
  input  logic [FLEN-1:0]            exp_result,
  input  logic [4:0]                 exp_flags,
  input  logic [1:0]                 exp_fmt,
  input  logic                       exp_f2i,
  input  logic                       dut_ready,
  input  logic [FLEN-1:0]            dut_result,
  input  logic [4:0]                 dut_flags,
  input  logic                       clear,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       mismatch,
  output logic [31:0]                pass_count,
  output logic [31:0]                fail_count,
  output logic                       orphan,
  output logic                       overflow,
  output logic                       halted,
  output logic                       fail_valid,
  output logic [FLEN-1:0]            fail_exp,
  output logic [FLEN-1:0]            fail_calc,
  output logic [4:0]                 fail_flags_diff
);

  sb_state_e      state_reg;
  logic           mismatch_reg;
  logic [31:0]    pass_count_reg;
  logic [31:0]    fail_count_reg;
  logic           orphan_reg;
  logic           overflow_reg;
  logic           fail_valid_reg;
  logic [FLEN-1:0] fail_exp_reg;
  logic [FLEN-1:0] fail_calc_reg;
  logic [4:0]     fail_flags_diff_reg;

  fp_exp_entry_t  push_data;
  fp_exp_entry_t  head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push_en;
  logic           pop_req;
  logic           pop_en;

  logic [63:0]    exp64;
  logic [63:0]    calc64;
  logic [63:0]    rdiff_raw;
  logic [63:0]    rdiff;
  logic [4:0]     fdiff;
  logic           cmp_fail;

  // ---------------------------------------------------------------------------
  // Queue control. clear overrides push and pop.
  // Halting blocks both sides.
  // ---------------------------------------------------------------------------
  assign exp_ready = !fifo_full && (state_reg == RUN);
  assign push_en   = exp_valid && exp_ready && !clear;
  assign pop_req   = dut_ready && (state_reg == RUN) && !clear;
  assign pop_en    = pop_req && !fifo_empty;

  always_comb begin
    push_data        = '0;
    push_data.result = 64'(exp_result);
    push_data.flags  = exp_flags;
    push_data.fmt    = exp_fmt;
    push_data.f2i    = exp_f2i;
  end

  fp_sb_fifo #(
    .DEPTH     (DEPTH),
    .payload_t (fp_exp_entry_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (clear),
    .push      (push_en),
    .push_data (push_data),
    .pop       (pop_en),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // ---------------------------------------------------------------------------
  // Compare on the queue head. The compare runs in 64 bits.
  // 32-bit builds zero-extend, so a double canonical NaN can never match there.
  // ---------------------------------------------------------------------------
  assign exp64     = (FLEN == 64) ? head.result : {32'b0, head.result[31:0]};
  assign calc64    = 64'(dut_result);
  assign rdiff_raw = exp64 ^ calc64;
  assign fdiff     = head.flags ^ dut_flags;

  always_comb begin
    rdiff = rdiff_raw;
    if (NAN_MASK && !head.f2i) begin
      // Canonical-NaN result: keep only the exponent and quiet-bit differences.
      if (head.fmt == 2'd0 && calc64[31:0] == SP_CANON_NAN) begin
        rdiff = {33'b0, rdiff_raw[30:22], 22'b0};
      end else if (head.fmt == 2'd1 && FLEN == 64 && calc64 == DP_CANON_NAN) begin
        rdiff = {1'b0, rdiff_raw[62:51], 51'b0};
      end
    end
  end

  assign cmp_fail = (rdiff != '0) || (fdiff != '0);

  // ---------------------------------------------------------------------------
  // Counters, sticky flags, first-failure capture and FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg           <= RUN;
      mismatch_reg        <= 1'b0;
      pass_count_reg      <= '0;
      fail_count_reg      <= '0;
      orphan_reg          <= 1'b0;
      overflow_reg        <= 1'b0;
      fail_valid_reg      <= 1'b0;
      fail_exp_reg        <= '0;
      fail_calc_reg       <= '0;
      fail_flags_diff_reg <= '0;
    end else if (clear) begin
      state_reg           <= RUN;
      mismatch_reg        <= 1'b0;
      pass_count_reg      <= '0;
      fail_count_reg      <= '0;
      orphan_reg          <= 1'b0;
      overflow_reg        <= 1'b0;
      fail_valid_reg      <= 1'b0;
      fail_exp_reg        <= '0;
      fail_calc_reg       <= '0;
      fail_flags_diff_reg <= '0;
    end else begin
      mismatch_reg <= 1'b0;
      if (pop_en) begin
        if (cmp_fail) begin
          mismatch_reg <= 1'b1;
          if (fail_count_reg != 32'hFFFF_FFFF) fail_count_reg <= fail_count_reg + 32'd1;
          if (!fail_valid_reg) begin
            fail_valid_reg      <= 1'b1;
            fail_exp_reg        <= exp64[FLEN-1:0];
            fail_calc_reg       <= dut_result;
            fail_flags_diff_reg <= fdiff;
          end
          if (STOP_ON_FAIL) state_reg <= HALT;
        end else begin
          if (pass_count_reg != 32'hFFFF_FFFF) pass_count_reg <= pass_count_reg + 32'd1;
        end
      end
      // A strobe with nothing queued is flagged.
      // Any entry pushed in the same cycle is not compared against it.
      if (pop_req && fifo_empty) orphan_reg <= 1'b1;
      if (exp_valid && !exp_ready) overflow_reg <= 1'b1;
    end
  end

  assign mismatch        = mismatch_reg;
  assign pass_count      = pass_count_reg;
  assign fail_count      = fail_count_reg;
  assign orphan          = orphan_reg;
  assign overflow        = overflow_reg;
  assign halted          = (state_reg == HALT);
  assign fail_valid      = fail_valid_reg;
  assign fail_exp        = fail_exp_reg;
  assign fail_calc       = fail_calc_reg;
  assign fail_flags_diff = fail_flags_diff_reg;

endmodule
